// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display blocks: digit count,
// segment bit order, hex glyph table and idle drive levels.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  // Segment bit positions within seg_out = {dp,g,f,e,d,c,b,a}
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Hex glyphs, a..g in bits 6:0; entry 15 first so HEX_FONT[n] is glyph n
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [7:0] COM_IDLE = 8'hFF;
  localparam logic [7:0] SEG_OFF  = 8'h00;

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } scan_phase_e;

endpackage

// File: rtl/seg_font_decoder.sv
// Combinational hex nibble to a..g segment pattern (active-high).
module seg_font_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup into the shared glyph set
  always_comb begin
    seg = HEX_FONT[nibble];
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 8-digit common-cathode 7-segment driver with per-slot
// blanking and a frame-synchronous shadow of the display inputs.
module seven_seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_WIDTH   = 16,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digit_data,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  output logic [7:0]  seg_out,
  output logic [7:0]  com_out,
  output logic        frame_tick
);

  localparam logic [SCAN_WIDTH-1:0] BLANK_LIM = SCAN_WIDTH'(BLANK_CYCLES);

  logic [SCAN_WIDTH-1:0] cnt;
  logic [2:0]            idx;
  logic [31:0]           d_sh;
  logic [7:0]            dp_sh;
  logic [7:0]            en_sh;

  logic        slot_end;
  logic        frame_end;
  logic        in_blank;
  scan_phase_e phase;
  logic [6:0]  glyph;
  logic [7:0]  seg_next;
  logic [7:0]  com_next;

  assign slot_end  = (cnt == '1);
  assign frame_end = slot_end && (idx == 3'(NUM_DIGITS - 1));

  // A zero-length blank window is handled at elaboration so no
  // always-false comparison is built.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt < BLANK_LIM);
    end
  endgenerate

  // Free-running slot counter and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (slot_end) idx <= idx + 1'b1;
    end
  end

  // Shadow capture only at the frame boundary to avoid torn updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_sh  <= '0;
      dp_sh <= '0;
      en_sh <= '0;
    end else if (frame_end) begin
      d_sh  <= digit_data;
      dp_sh <= dp_in;
      en_sh <= digit_en;
    end
  end

  seg_font_decoder u_font (
    .nibble (d_sh[{idx, 2'b00} +: 4]),
    .seg    (glyph)
  );

  // Phase decode and next output values from current cnt/idx/shadow
  always_comb begin
    phase    = in_blank ? PH_BLANK : PH_DRIVE;
    seg_next = SEG_OFF;
    com_next = COM_IDLE;
    if (phase == PH_DRIVE && en_sh[idx]) begin
      seg_next[SEG_G:SEG_A] = glyph;
      seg_next[SEG_DP]      = dp_sh[idx];
      com_next              = ~(8'h01 << idx);
    end
  end

  // Registered outputs; frame_tick lands in the first cycle of new shadow data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= SEG_OFF;
      com_out    <= COM_IDLE;
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= seg_next;
      com_out    <= com_next;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (SCAN_WIDTH=4, BLANK_CYCLES=2)
// against a cycle-count based reference model.
module tb_seven_seg_scan_driver;

  localparam int unsigned SW    = 4;
  localparam int unsigned BC    = 2;
  localparam int unsigned SLOT  = 1 << SW;
  localparam int unsigned FRAME = 8 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] digit_data = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  digit_en = '0;
  logic [7:0]  seg_out;
  logic [7:0]  com_out;
  logic        frame_tick;

  seven_seg_scan_driver #(
    .SCAN_WIDTH   (SW),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit_data (digit_data),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .seg_out    (seg_out),
    .com_out    (com_out),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: clock edges since reset release plus the displayed frame's values
  int unsigned s = 0;
  logic [31:0] m_d  = '0;
  logic [7:0]  m_dp = '0;
  logic [7:0]  m_en = '0;

  logic [6:0] font_tb [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h (t=%0t, edge %0d)", tag, got, exp, $time, s);
    end
  endtask

  // One clock: predict outputs from pre-edge position, advance, then compare
  task automatic tick_cycle();
    int unsigned c, i;
    logic [3:0] nib;
    logic [7:0] e_seg, e_com, e_tick, n_low;
    c = s % SLOT;
    i = (s / SLOT) % 8;
    if (c < BC || !m_en[i]) begin
      e_seg = 8'h00;
      e_com = 8'hFF;
    end else begin
      nib   = m_d[4*i +: 4];
      e_com = ~(8'h01 << i);
      e_seg = {m_dp[i], font_tb[nib]};
    end
    e_tick = (s % FRAME == FRAME - 1) ? 8'h01 : 8'h00;
    if (e_tick[0]) begin
      m_d  = digit_data;
      m_dp = dp_in;
      m_en = digit_en;
    end
    @(posedge clk);
    #1;
    s++;
    check_eq("seg_out", seg_out, e_seg);
    check_eq("com_out", com_out, e_com);
    check_eq("frame_tick", {7'd0, frame_tick}, e_tick);
    n_low = 8'($countones(~com_out));
    if (n_low > 1) check_eq("com_onehot", n_low, 8'h01);
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) tick_cycle();
  endtask

  task automatic run_until(input int unsigned pos);
    int unsigned guard;
    guard = 0;
    while (s % FRAME != pos && guard < 4 * FRAME) begin
      tick_cycle();
      guard++;
    end
    if (s % FRAME != pos) check_eq("run_until_timeout", 8'(s % FRAME), 8'(pos));
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_seg", seg_out, 8'h00);
    check_eq("rst_com", com_out, 8'hFF);
    check_eq("rst_tick", {7'd0, frame_tick}, 8'h00);
    rst_n = 1'b1;

    // Full font, first half; first frame after reset stays dark
    digit_data = 32'h7654_3210;
    digit_en   = 8'hFF;
    dp_in      = 8'h01;
    run(FRAME);
    run(FRAME);

    // Second half of the font; old glyphs persist until the next frame
    digit_data = 32'hFEDC_BA98;
    dp_in      = 8'hA6;
    run(2 * FRAME);

    // Tear-free update: change inputs mid-frame at slot 3
    run_until(3 * SLOT + 5);
    digit_data = $urandom;
    dp_in      = 8'($urandom);
    run(2 * FRAME);

    // Enable mask
    digit_en = 8'b1010_0101;
    run(2 * FRAME);

    // Random inputs changing at random times
    for (int r = 0; r < 20; r++) begin
      digit_data = $urandom;
      dp_in      = 8'($urandom);
      digit_en   = 8'($urandom);
      run($urandom_range(1, 200));
    end
    run(FRAME);

    // Mid-slot reset at slot 5, cycle 9
    digit_en = 8'hFF;
    run_until(5 * SLOT + 9);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_seg", seg_out, 8'h00);
    check_eq("midrst_com", com_out, 8'hFF);
    check_eq("midrst_tick", {7'd0, frame_tick}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check_eq("midrst_hold_com", com_out, 8'hFF);
    rst_n = 1'b1;
    s    = 0;
    m_d  = '0;
    m_dp = '0;
    m_en = '0;
    run(2 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Output-side display driver for the board's 8-digit common-cathode 7-segment array. It pairs with the DIP input driver: switches come in through debounce, and results go out through this block. The block time-multiplexes 8 hex digits, with one digit lit per scan slot. A blanking gap at the start of each slot suppresses ghosting. All inputs are captured into a shadow register once per frame, so the display never shows a torn update.

## Interface
- SCAN_WIDTH, 16, slot-counter width.
  - Slot length is 2^SCAN_WIDTH clk cycles, about 1.31 ms at 50 MHz.
  - Simulation uses 4.
- BLANK_CYCLES, 64, blanking cycles at the start of every slot.
  - Legal range is 0 to 2^SCAN_WIDTH-1.
  - 0 disables blanking.
  - Simulation uses 2.
- clk, input, 1, system clock (50 MHz).
- rst_n, input, 1, reset: asynchronous, active-low.
- digit_data, input, 32, eight hex nibbles; nibble k ([4k+3:4k]) is digit k.
- dp_in, input, 8, decimal point per digit; bit k is digit k, 1 = lit.
- digit_en, input, 8, per-digit enable; 0 = digit dark.
- seg_out, output, 8, segment drive {dp,g,f,e,d,c,b,a}, active-high.
- com_out, output, 8, digit common select, active-low; bit k selects digit k.
- frame_tick, output, 1, one-cycle pulse marking the first cycle of a new frame.

## Operation
- Slot counter cnt (SCAN_WIDTH bits) and digit index idx (3 bits) are free-running.
  - cnt increments every clk.
  - When cnt reaches all-ones, it wraps to 0 and idx increments mod 8 (7 -> 0).
- Shadow registers d_sh[31:0], dp_sh[7:0] and en_sh[7:0] capture digit_data, dp_in and digit_en.
  - Capture happens on the edge where cnt wraps and idx goes 7 -> 0.
  - No other edge changes the shadow registers.
  - Input changes mid-frame take effect only at the next frame start.
- Slot phases, decoded from the current cnt:
  - BLANK, while cnt < BLANK_CYCLES: com_out = 8'hFF, seg_out = 8'h00.
  - DRIVE, otherwise:
    - If en_sh[idx] = 1: com_out has only bit idx low, and seg_out = {dp_sh[idx], font(d_sh[4*idx+:4])}.
    - If en_sh[idx] = 0: com_out = 8'hFF, seg_out = 8'h00.
- Font for a..g, given as hex with dp excluded:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- At most one com_out bit is ever low. It is never low while cnt is inside a BLANK window.
- frame_tick is high for exactly one cycle: the cycle in which the shadow holds the newly captured values.
  - Period is 8 * 2^SCAN_WIDTH cycles.
- Reset (asynchronous assert, synchronous release):
  - cnt = 0, idx = 0, shadow = 0.
  - seg_out = 8'h00, com_out = 8'hFF, frame_tick = 0.
  - The first frame after reset is fully dark, because en_sh = 0.
  - The first capture happens at the end of that first frame.
- Reset asserted mid-slot forces the reset values immediately. Scanning restarts at digit 0 with a BLANK window.

## Timing
- seg_out, com_out and frame_tick are registered outputs with no combinational path from inputs.
  - They reflect the cnt/idx/shadow state of the previous cycle, a fixed 1-cycle lag.
- Latency from input change to display:
  - At most 8 * 2^SCAN_WIDTH + BLANK_CYCLES + 1 cycles.
  - At least BLANK_CYCLES + 1 cycles after capture.
- Slot k drive window: 2^SCAN_WIDTH - BLANK_CYCLES cycles.
- com_out transitions, from one digit to the next, always pass through 8'hFF for BLANK_CYCLES cycles.
  - Exception: when BLANK_CYCLES = 0, outputs switch directly between digits.
- Inputs are assumed synchronous to clk; this block contains no synchronizers.

## Structure
- Shared package seg_pkg:
  - NUM_DIGITS = 8.
  - Segment bit-order constants.
  - The 16-entry hex font constant array.
  - COM_IDLE = 8'hFF.
- Sub-module seg_font_decoder: combinational 4-bit nibble to 7-bit a..g. It is reused by other display blocks.
- Top: counter and index logic, shadow capture, phase decode, and output registers.

## Test plan
Parameters for all scenarios: SCAN_WIDTH = 4, BLANK_CYCLES = 2.
- **Reset state.** Hold rst_n low, then release.
  - Outputs are 00 / FF / 0 during reset.
  - The first frame (128 cycles) keeps com_out = FF throughout.
  - frame_tick pulses at cycle 128.
- **Full font.** Set digit_data = 32'h7654_3210, digit_en = FF, dp_in = 8'h01.
  - Digit 0 shows seg_out = BF (3F plus dp), with com_out = FE.
  - Digit 3 shows seg_out = 4F, with com_out = F7.
  - Repeat with 32'hFEDC_BA98 and check the remaining 8 glyphs.
- **Blanking.** Run any frame.
  - Each slot shows com_out = FF for exactly 2 cycles, then 14 drive cycles.
  - A one-hot-low check on com_out never fails.
- **Tear-free update.** Change digit_data mid-frame, at slot 3.
  - Slots 3 to 7 still show the old values.
  - New values appear in slot 0, right after frame_tick.
- **Enable mask.** Set digit_en = 8'b1010_0101.
  - Slots 1, 3, 4 and 6 hold com_out = FF with seg_out = 00 for the whole slot.
- **Mid-slot reset.** Assert rst_n at slot 5, cycle 9.
  - Outputs go to 00 / FF immediately.
  - After release, scanning resumes at digit 0 and the frame is dark.
